// File: rtl/alu_pkg.sv
// Shared types for the ALU request arbiter: sequencer states, opcode constants
// and the requester-id type.
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    CAPTURE,
    DONE
  } arb_state_t;

  localparam logic [3:0] OP_LOAD = 4'hF;

  // 0 = front-panel path, 1 = host command port
  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: combinational winner selection, pointer to the last
// granted requester updated only when the pick is accepted.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       valid,
  output req_id_t    winner
);

  req_id_t last_grant;

  always_comb begin
    valid  = |req;
    winner = req[1];
    // contention goes to whoever was not served last
    if (req == 2'b11) winner = ~last_grant;
  end

  // reset value 1 lets requester 0 win the first tie
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/alu_request_arbiter.sv
// Arbitrates two requesters onto the shared ALU datapath and sequences A/B load,
// execute and Y capture. Optional grant counters under ALU_ARB_STATS_EN.
//
// state   | meaning
// IDLE    | waiting for a request; at least one cycle between operations
// LOAD_A  | grant pulse, operand A driven onto operand_bus, enable_A
// LOAD_B  | operand B driven onto operand_bus, enable_B
// EXEC    | opcode held for ALU_LAT cycles (down-counter to zero)
// CAPTURE | enable_Y, result captured from alu_y at end of cycle
// DONE    | one-cycle done pulse to the owning requester
module alu_request_arbiter
  import alu_pkg::*;
#(
  parameter int W       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [3:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [3:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         grant0,
  output logic         grant1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy,
  input  logic [W-1:0] alu_y,
  output logic [W-1:0] operand_bus,
  output logic         enable_A,
  output logic         enable_B,
  output logic         enable_Y,
  output logic [3:0]   operation_select
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  arb_state_t    state, state_nx;
  logic [CW-1:0] cnt;
  req_id_t       owner;
  logic [3:0]    op_q;
  logic [W-1:0]  a_q, b_q;

  logic          pick_valid;
  req_id_t       pick_id;
  logic          accept;
  logic [3:0]    op_src;
  logic [W-1:0]  a_src, b_src;

  logic          grant0_nx, grant1_nx, done0_nx, done1_nx, busy_nx;
  logic          enable_A_nx, enable_B_nx, enable_Y_nx;
  logic [W-1:0]  bus_nx;
  logic [3:0]    opsel_nx;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .accept (accept),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_comb begin
    accept = (state == IDLE) && pick_valid;
    op_src = pick_id ? op1 : op0;
    a_src  = pick_id ? a1 : a0;
    b_src  = pick_id ? b1 : b0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = LOAD_A;
      LOAD_A:  state_nx = LOAD_B;
      LOAD_B:  state_nx = EXEC;
      EXEC:    if (cnt == '0) state_nx = CAPTURE;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs are registered, so they are decoded from the state being entered
  always_comb begin
    grant0_nx   = accept & ~pick_id;
    grant1_nx   = accept & pick_id;
    done0_nx    = 1'b0;
    done1_nx    = 1'b0;
    busy_nx     = (state_nx != IDLE);
    enable_A_nx = 1'b0;
    enable_B_nx = 1'b0;
    enable_Y_nx = 1'b0;
    bus_nx      = '0;
    opsel_nx    = '0;
    case (state_nx)
      LOAD_A: begin
        enable_A_nx = 1'b1;
        bus_nx      = a_src;
        opsel_nx    = op_src;
      end
      LOAD_B: begin
        enable_B_nx = 1'b1;
        bus_nx      = b_q;
        opsel_nx    = op_q;
      end
      EXEC: opsel_nx = op_q;
      CAPTURE: begin
        enable_Y_nx = 1'b1;
        opsel_nx    = op_q;
      end
      DONE: begin
        done0_nx = ~owner;
        done1_nx = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      owner            <= 1'b0;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      grant0           <= 1'b0;
      grant1           <= 1'b0;
      done0            <= 1'b0;
      done1            <= 1'b0;
      busy             <= 1'b0;
      result           <= '0;
      operand_bus      <= '0;
      enable_A         <= 1'b0;
      enable_B         <= 1'b0;
      enable_Y         <= 1'b0;
      operation_select <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD_B) begin
        cnt <= CW'(ALU_LAT - 1);
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (accept) begin
        owner <= pick_id;
        op_q  <= op_src;
        a_q   <= a_src;
        b_q   <= b_src;
      end
      if (state == CAPTURE) result <= alu_y;
      grant0           <= grant0_nx;
      grant1           <= grant1_nx;
      done0            <= done0_nx;
      done1            <= done1_nx;
      busy             <= busy_nx;
      operand_bus      <= bus_nx;
      enable_A         <= enable_A_nx;
      enable_B         <= enable_B_nx;
      enable_Y         <= enable_Y_nx;
      operation_select <= opsel_nx;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) driven
// by directed and random requests, checked cycle by cycle against a transaction model.
module tb_alu_request_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_v[2], req1_v[2];
  logic [3:0] op0_v[2], op1_v[2];
  logic [7:0] a0_v[2], b0_v[2], a1_v[2], b1_v[2];
  logic       grant0_v[2], grant1_v[2], done0_v[2], done1_v[2], busy_v[2];
  logic       ena_v[2], enb_v[2], eny_v[2];
  logic [7:0] result_v[2], bus_v[2], y_v[2];
  logic [3:0] opsel_v[2];
  logic [7:0] ra[2], rb[2];
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0_v[2], gc1_v[2];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cur_k  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      OP_LOAD: return b;
      default: return a ^ b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_request_arbiter #(.W(8), .ALU_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .req0             (req0_v[g]),
      .op0              (op0_v[g]),
      .a0               (a0_v[g]),
      .b0               (b0_v[g]),
      .req1             (req1_v[g]),
      .op1              (op1_v[g]),
      .a1               (a1_v[g]),
      .b1               (b1_v[g]),
      .grant0           (grant0_v[g]),
      .grant1           (grant1_v[g]),
      .done0            (done0_v[g]),
      .done1            (done1_v[g]),
      .result           (result_v[g]),
      .busy             (busy_v[g]),
      .alu_y            (y_v[g]),
      .operand_bus      (bus_v[g]),
      .enable_A         (ena_v[g]),
      .enable_B         (enb_v[g]),
      .enable_Y         (eny_v[g]),
      .operation_select (opsel_v[g])
`ifdef ALU_ARB_STATS_EN
      ,
      .grant_cnt0       (gc0_v[g]),
      .grant_cnt1       (gc1_v[g])
`endif
    );
  end

  // ALU datapath model: A/B registers loaded from operand_bus, combinational Y
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ena_v[g]) ra[g] <= bus_v[g];
      if (enb_v[g]) rb[g] <= bus_v[g];
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) y_v[g] = alu_f(opsel_v[g], ra[g], rb[g]);
  end

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %0h, expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %0h, expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input int r, input logic on, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (r == 0) begin
      req0_v[k] = on; op0_v[k] = op; a0_v[k] = a; b0_v[k] = b;
    end else begin
      req1_v[k] = on; op1_v[k] = op; a1_v[k] = a; b1_v[k] = b;
    end
  endtask

  task automatic drop_req(input int k, input int r);
    if (r == 0) req0_v[k] = 1'b0;
    else        req1_v[k] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_cleared(input int k);
    cur_k = k;
    chkb("rst_grant0", grant0_v[k], 1'b0);
    chkb("rst_grant1", grant1_v[k], 1'b0);
    chkb("rst_done0", done0_v[k], 1'b0);
    chkb("rst_done1", done1_v[k], 1'b0);
    chkb("rst_busy", busy_v[k], 1'b0);
    chkb("rst_enable_A", ena_v[k], 1'b0);
    chkb("rst_enable_B", enb_v[k], 1'b0);
    chkb("rst_enable_Y", eny_v[k], 1'b0);
    chkv("rst_operand_bus", 16'(bus_v[k]), 16'h0);
    chkv("rst_op_select", 16'(opsel_v[k]), 16'h0);
    chkv("rst_result", 16'(result_v[k]), 16'h0);
  endtask

  // Expects the request(s) to have been presented while the DUT sits in IDLE;
  // the grant then follows one cycle later and the sequence is fixed by ALU_LAT.
  task automatic run_op(input int k, input int owner, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b, input bit scramble);
    int lat, w;
    logic [7:0] ey;
    logic g_own, g_oth, d_own, d_oth;
    cur_k = k;
    lat = (k == 0) ? 1 : 3;
    ey  = alu_f(op, a, b);
    w   = 0;
    while (grant0_v[k] !== 1'b1 && grant1_v[k] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chkv("grant_latency", 16'(w), 16'd1);
    for (int c = 0; c <= 4 + lat; c++) begin
      if (c > 0) @(negedge clk);
      g_own = (owner == 0) ? grant0_v[k] : grant1_v[k];
      g_oth = (owner == 0) ? grant1_v[k] : grant0_v[k];
      d_own = (owner == 0) ? done0_v[k] : done1_v[k];
      d_oth = (owner == 0) ? done1_v[k] : done0_v[k];
      chkb("grant_owner", g_own, c == 0);
      chkb("grant_other", g_oth, 1'b0);
      chkb("enable_A", ena_v[k], c == 0);
      chkb("enable_B", enb_v[k], c == 1);
      chkb("enable_Y", eny_v[k], c == 2 + lat);
      chkv("operand_bus", 16'(bus_v[k]), 16'((c == 0) ? a : (c == 1) ? b : 8'h00));
      chkv("op_select", 16'(opsel_v[k]), 16'((c <= 2 + lat) ? op : 4'h0));
      chkb("busy", busy_v[k], c <= 3 + lat);
      chkb("done_owner", d_own, c == 3 + lat);
      chkb("done_other", d_oth, 1'b0);
      if (c >= 3 + lat) chkv("result", 16'(result_v[k]), 16'(ey));
      if (c == 0 && scramble)
        set_req(k, owner, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      if (c == 3 + lat) drop_req(k, owner);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         pend[2];
    logic [3:0] p_op[2];
    logic [7:0] p_a[2], p_b[2];
    int         last, win;
    bit         scr;

    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 1'b0, 4'h0, 8'h00, 8'h00);
      set_req(k, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_cleared(0);
    chk_cleared(1);
    reset = 1'b1;

    // single requester 0, ALU_LAT=1
    set_req(0, 0, 1'b1, 4'h0, 8'h12, 8'h34);
    run_op(0, 0, 4'h0, 8'h12, 8'h34, 1'b0);
    chkv("add_result", 16'(result_v[0]), 16'h0046);

    // simultaneous pairs from reset: 0, then 1, then 0 again
    do_reset();
    set_req(0, 0, 1'b1, 4'h1, 8'h05, 8'h03);
    set_req(0, 1, 1'b1, 4'h0, 8'h20, 8'h22);
    run_op(0, 0, 4'h1, 8'h05, 8'h03, 1'b0);
    run_op(0, 1, 4'h0, 8'h20, 8'h22, 1'b0);
    set_req(0, 0, 1'b1, 4'h2, 8'hF0, 8'h3C);
    set_req(0, 1, 1'b1, 4'h3, 8'h01, 8'h80);
    run_op(0, 0, 4'h2, 8'hF0, 8'h3C, 1'b0);
    run_op(0, 1, 4'h3, 8'h01, 8'h80, 1'b0);

    // ALU_LAT=3 instance, requester 1
    set_req(1, 1, 1'b1, 4'h2, 8'hCC, 8'h0F);
    run_op(1, 1, 4'h2, 8'hCC, 8'h0F, 1'b0);
    chkv("lat3_result", 16'(result_v[1]), 16'h000C);

    // payload change and req drop right after grant must not matter
    set_req(0, 0, 1'b1, 4'h0, 8'h12, 8'h34);
    run_op(0, 0, 4'h0, 8'h12, 8'h34, 1'b1);

    // reset in EXEC aborts without done, then a fresh request completes
    cur_k = 0;
    set_req(0, 0, 1'b1, 4'h1, 8'h80, 8'h01);
    @(negedge clk);
    chkb("abort_grant", grant0_v[0], 1'b1);
    @(negedge clk);
    @(negedge clk);
    chkv("abort_exec_opsel", 16'(opsel_v[0]), 16'h0001);
    chkb("abort_exec_busy", busy_v[0], 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk_cleared(0);
    reset = 1'b1;
    set_req(0, 0, 1'b1, OP_LOAD, 8'h33, 8'h44);
    run_op(0, 0, OP_LOAD, 8'h33, 8'h44, 1'b0);

    // random traffic against the round-robin transaction model
    for (int k = 0; k < 2; k++) begin
      drop_req(k, 0);
      drop_req(k, 1);
      do_reset();
      last = 1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
        for (int r = 0; r < 2; r++) begin
          if (!pend[r] && $urandom_range(0, 1) == 1) begin
            pend[r] = 1'b1;
            p_op[r] = 4'($urandom_range(0, 15));
            p_a[r]  = 8'($urandom);
            p_b[r]  = 8'($urandom);
            set_req(k, r, 1'b1, p_op[r], p_a[r], p_b[r]);
          end
        end
        if (!pend[0] && !pend[1]) begin
          win = int'($urandom_range(0, 1));
          pend[win] = 1'b1;
          p_op[win] = 4'($urandom_range(0, 15));
          p_a[win]  = 8'($urandom);
          p_b[win]  = 8'($urandom);
          set_req(k, win, 1'b1, p_op[win], p_a[win], p_b[win]);
        end
        if (pend[0] && pend[1]) win = (last == 0) ? 1 : 0;
        else                    win = pend[0] ? 0 : 1;
        last = win;
        scr = ($urandom_range(0, 3) == 0);
        run_op(k, win, p_op[win], p_a[win], p_b[win], scr);
        pend[win] = 1'b0;
      end
      drop_req(k, 0);
      drop_req(k, 1);
    end

`ifdef ALU_ARB_STATS_EN
    cur_k = 0;
    do_reset();
    chkv("cnt0_after_reset", gc0_v[0], 16'd0);
    chkv("cnt1_after_reset", gc1_v[0], 16'd0);
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1, 1'b1, 4'h0, 8'(i), 8'h10);
      run_op(0, 1, 4'h0, 8'(i), 8'h10, 1'b0);
    end
    cur_k = 0;
    chkv("cnt1_three", gc1_v[0], 16'd3);
    chkv("cnt0_zero", gc0_v[0], 16'd0);
    do_reset();
    chkv("cnt0_cleared", gc0_v[0], 16'd0);
    chkv("cnt1_cleared", gc1_v[0], 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
Shares the single ALU datapath (A/B operand registers, Y result register) between two requesters: requester 0 is the front-panel button/switch path and requester 1 is the host command port. It arbitrates round-robin, latches the winning request, and sequences the datapath through its stages: load A, load B, execute for a fixed latency, capture Y. It returns the result with a one-cycle done pulse. Sits between the requesters and the ALU datapath, replacing direct button-driven enable control.

Parameters:
W, 8, operand/result width
ALU_LAT, 1, cycles operation_select must be held before Y is valid (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req0  in  1  requester 0 request; held until done0
op0  in  4  requester 0 opcode
a0  in  W  requester 0 operand A
b0  in  W  requester 0 operand B
req1  in  1  requester 1 request; held until done1
op1  in  4  requester 1 opcode
a1  in  W  requester 1 operand A
b1  in  W  requester 1 operand B
grant0  out  1  one-cycle pulse: request 0 accepted, payload latched
grant1  out  1  one-cycle pulse: request 1 accepted
done0  out  1  one-cycle pulse: result valid for requester 0
done1  out  1  one-cycle pulse: result valid for requester 1
result  out  W  last captured ALU result; stable until next capture
busy  out  1  high in every state except IDLE
alu_y  in  W  ALU datapath Y output
operand_bus  out  W  data presented to A/B registers
enable_A  out  1  load A register from operand_bus
enable_B  out  1  load B register from operand_bus
enable_Y  out  1  load Y register
operation_select  out  4  opcode to ALU

Behaviour:
- All outputs registered. Reset (reset==0 at posedge) clears all outputs to 0, sets state to IDLE and last_grant to 1, so requester 0 wins the first tie.
- States: IDLE -> LOAD_A -> LOAD_B -> EXEC (ALU_LAT cycles, down-counter) -> CAPTURE -> DONE -> IDLE.
- IDLE with any req: pick the winner.
  - Single requester: that one wins.
  - Both requesting: the one != last_grant wins.
  - Latch op/a/b of the winner plus owner id, update last_grant, pulse grant<owner> in the cycle after the decision.
- LOAD_A: enable_A=1, operand_bus=latched a. LOAD_B: enable_B=1, operand_bus=latched b. enable_A/enable_B never both high.
- operation_select = latched op from LOAD_A through CAPTURE; 0 in IDLE/DONE.
- EXEC: enables low; counter loaded with ALU_LAT-1, leave when counter==0.
- CAPTURE: enable_Y=1; result <= alu_y at end of this cycle.
- DONE: done<owner>=1 for exactly one cycle; busy still 1.
- Return to IDLE; IDLE lasts at least one cycle between operations.
- Latency: request sampled in IDLE at cycle t -> done at t+4+ALU_LAT.
- Payload changes after grant are ignored.
- Requester dropping req mid-operation: the operation completes and done still pulses.
- Losing requester keeps req high and is served next (no starvation; max wait = one operation).
- Opcode is not interpreted; LOAD (4'hF) and all others take the same sequence.
- reset low mid-operation: abort on that edge; no done pulse; result cleared to 0.
- operand_bus = 0 outside LOAD_A/LOAD_B.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16-bit each), incremented on the matching grant pulse. They saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package alu_pkg holds the state enum (IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, DONE), the opcode constant OP_LOAD=4'hF, and the requester-id type.
- One sub-module, rr_arbiter2: a 2-way round-robin pick with last_grant pointer. It is combinational pick plus registered pointer update on accept.

Test Plan:
- Single req0 (op=4'h0 ADD, a0=8'h12, b0=8'h34), alu_y model = a+b, ALU_LAT=1 -> grant0 at t+1, enable_A at t+1 with operand_bus=8'h12, enable_B at t+2 with 8'h34, enable_Y at t+4, done0 at t+5, result=8'h46, done1 never.
- req0 and req1 asserted together from reset -> req0 served first; req1 granted in the cycle after the first IDLE following done0; third simultaneous pair -> req0 (alternation).
- ALU_LAT=3, req1 op=4'h2 -> operation_select=4'h2 held for exactly 3 EXEC cycles; done1 at t+7.
- a0 changed from 8'h12 to 8'hFF one cycle after grant0 -> operand_bus shows 8'h12 in LOAD_A; result unaffected.
- reset driven low during EXEC -> next edge: all outputs 0, busy=0, no done pulse; a fresh req0 afterward completes normally.
- With ALU_ARB_STATS_EN, 3 grants to req1 -> grant_cnt1=3, grant_cnt0=0; reset -> both 0.
